// File: rtl/memory_x_sched.sv
// ---------------------------------------------------------------------------
// memory_x_sched
//
// Purpose:
//   Schedules burst reads of one timestep vector (NUM words) out of memory_x
//   for two requesters: requester 0 (forward pass) and requester 1 (backprop).
//   A granted burst issues NUM sequential read addresses starting at
//   b*NUM*TIMESTEP + t*NUM.  memory_x has a one-cycle registered read, so
//   vld/idx/last lag the address by one cycle.  An extra FLUSH cycle carries
//   the final word, and one IDLE cycle always separates two bursts.
//   Arbitration is round-robin, with requester 0 favoured out of reset.
//   Requests naming a timestep >= TIMESTEP are rejected with an err pulse.
//
// Ports:
//   clk          - sole clock, rising edge
//   rst          - asynchronous active-low reset
//   req0/req1    - burst request from requester 0 / requester 1
//   t0/t1        - requested timestep (TS_W bits), sampled with the request
//   b0/b1        - requested bank, sampled with the request
//   addr         - registered read address to memory_x (12 bits)
//   gnt0/gnt1    - grant, high for every BURST and FLUSH cycle of the owner
//   vld          - memory_x read data is valid this cycle
//   idx          - word index (0..NUM-1) of the data qualified by vld
//   last         - high with vld on word NUM-1
//   err0/err1    - one-cycle pulse in the IDLE cycle that rejects a request
// ---------------------------------------------------------------------------
module memory_x_sched #(
    parameter int NUM      = 53,
    parameter int TIMESTEP = 7,
    parameter int TS_W     = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0,
    input  logic            req1,
    input  logic [TS_W-1:0] t0,
    input  logic [TS_W-1:0] t1,
    input  logic            b0,
    input  logic            b1,
    output logic [11:0]     addr,
    output logic            gnt0,
    output logic            gnt1,
    output logic            vld,
    output logic [5:0]      idx,
    output logic            last,
    output logic            err0,
    output logic            err1
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [11:0]   BANK_STRIDE = 12'(NUM * TIMESTEP);
    localparam logic [11:0]   ROW_STRIDE  = 12'(NUM);
    localparam logic [5:0]    LAST_CNT    = 6'(NUM - 1);
    localparam logic [TS_W:0] TS_LIMIT    = TIMESTEP[TS_W:0];

    state_t          r_state;
    state_t          w_stateNext;
    logic [11:0]     r_addr;
    logic [5:0]      r_cnt;
    logic            r_gnt0;
    logic            r_gnt1;
    logic            r_vld;
    logic [5:0]      r_idx;
    logic            r_last;
    logic            r_prio1;

    logic            w_tOk0;
    logic            w_tOk1;
    logic            w_legal0;
    logic            w_legal1;
    logic            w_grant0;
    logic            w_grant1;
    logic [TS_W-1:0] w_selT;
    logic            w_selB;
    logic [11:0]     w_base;

    // A request is only legal when its timestep exists in the bank; the
    // compare is widened by one bit so TIMESTEP itself is representable.
    assign w_tOk0   = ({1'b0, t0} < TS_LIMIT);
    assign w_tOk1   = ({1'b0, t1} < TS_LIMIT);
    assign w_legal0 = req0 & w_tOk0;
    assign w_legal1 = req1 & w_tOk1;

    // Rejections are reported in the very IDLE cycle that samples them, so
    // err is decoded combinationally and gated by reset to stay low there.
    assign err0 = rst & (r_state == IDLE) & req0 & ~w_tOk0;
    assign err1 = rst & (r_state == IDLE) & req1 & ~w_tOk1;

    // Burst start address for whichever requester wins arbitration.
    assign w_base = (w_selB ? BANK_STRIDE : 12'd0) + (12'(w_selT) * ROW_STRIDE);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state and arbitration.  Round-robin: when both are legal, the
    // requester not served last wins; a lone legal request always wins,
    // even if the other requester was rejected in the same cycle.
    always_comb begin
        w_stateNext = r_state;
        w_grant0    = 1'b0;
        w_grant1    = 1'b0;
        w_selT      = t0;
        w_selB      = b0;
        case (r_state)
            IDLE: begin
                w_grant0 = w_legal0 & (~w_legal1 | ~r_prio1);
                w_grant1 = w_legal1 & ~w_grant0;
                if (w_grant1) begin
                    w_selT = t1;
                    w_selB = b1;
                end
                if (w_grant0 | w_grant1) begin
                    w_stateNext = BURST;
                end
            end
            BURST: begin
                if (r_cnt == LAST_CNT) begin
                    w_stateNext = FLUSH;
                end
            end
            FLUSH: begin
                w_stateNext = IDLE;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // Datapath.  The base address is captured at grant and then only
    // incremented, so requester inputs during a burst have no effect.  The
    // data-side outputs are a one-cycle delayed copy of the BURST cycles,
    // which makes FLUSH the cycle that carries the final word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr  <= 12'd0;
            r_cnt   <= 6'd0;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_vld   <= 1'b0;
            r_idx   <= 6'd0;
            r_last  <= 1'b0;
            r_prio1 <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant0 | w_grant1) begin
                        r_addr  <= w_base;
                        r_cnt   <= 6'd0;
                        r_gnt0  <= w_grant0;
                        r_gnt1  <= w_grant1;
                        r_prio1 <= w_grant0;
                    end
                end
                BURST: begin
                    if (r_cnt != LAST_CNT) begin
                        r_addr <= r_addr + 12'd1;
                        r_cnt  <= r_cnt + 6'd1;
                    end
                end
                FLUSH: begin
                    r_gnt0 <= 1'b0;
                    r_gnt1 <= 1'b0;
                end
                default: begin
                    r_gnt0 <= 1'b0;
                    r_gnt1 <= 1'b0;
                end
            endcase
            r_vld  <= (r_state == BURST);
            r_idx  <= (r_state == BURST) ? r_cnt : 6'd0;
            r_last <= (r_state == BURST) && (r_cnt == LAST_CNT);
        end
    end

    assign addr = r_addr;
    assign gnt0 = r_gnt0;
    assign gnt1 = r_gnt1;
    assign vld  = r_vld;
    assign idx  = r_idx;
    assign last = r_last;

endmodule

// File: tb/tb_memory_x_sched.sv
// ---------------------------------------------------------------------------
// tb_memory_x_sched
//
// Purpose:
//   Bench for memory_x_sched.  Stimulus tasks issue requests while the
//   scheduler is idle; a reference model works out the winner from the
//   round-robin rule and queues the NUM expected words of the burst.  An
//   independent monitor pops one expected word each time vld is high.
// ---------------------------------------------------------------------------
module tb_memory_x_sched;

    localparam int NUM      = 53;
    localparam int TIMESTEP = 7;
    localparam int TS_W     = 3;

    logic            clk;
    logic            rst;
    logic            req0;
    logic            req1;
    logic [TS_W-1:0] t0;
    logic [TS_W-1:0] t1;
    logic            b0;
    logic            b1;
    logic [11:0]     addr;
    logic            gnt0;
    logic            gnt1;
    logic            vld;
    logic [5:0]      idx;
    logic            last;
    logic            err0;
    logic            err1;

    typedef struct {
        int addr;
        int idx;
        bit last;
        int owner;
    } exp_t;

    exp_t        expQ[$];
    int          modelPrio;
    int          total;
    int          bad;
    int          gntCycles;
    logic [11:0] prevAddr;

    memory_x_sched #(
        .NUM      (NUM),
        .TIMESTEP (TIMESTEP),
        .TS_W     (TS_W)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .req0 (req0),
        .req1 (req1),
        .t0   (t0),
        .t1   (t1),
        .b0   (b0),
        .b1   (b1),
        .addr (addr),
        .gnt0 (gnt0),
        .gnt1 (gnt1),
        .vld  (vld),
        .idx  (idx),
        .last (last),
        .err0 (err0),
        .err1 (err1)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something wedges beyond all the bounded waits.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
        end
    endtask

    // Reference arbitration: legal means requested and timestep in range;
    // both legal goes to the priority holder, otherwise the lone legal one.
    function automatic int pickWinner(input bit r0, input int tv0, input bit r1, input int tv1,
                                      input int prio);
        bit l0;
        bit l1;
        l0 = r0 && (tv0 < TIMESTEP);
        l1 = r1 && (tv1 < TIMESTEP);
        if (l0 && l1) return prio;
        if (l0) return 0;
        if (l1) return 1;
        return -1;
    endfunction

    // Monitor: every vld cycle consumes one expected word; the address is
    // the one presented on the previous cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (gnt0 || gnt1) gntCycles++;
            if (gnt0 && gnt1) checkOutput("dual_grant", {30'd0, gnt1, gnt0}, 1);
            if (vld) begin
                if (expQ.size() == 0) begin
                    checkOutput("spurious_vld", int'(vld), 0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("word_addr", int'(prevAddr), e.addr);
                    checkOutput("word_idx", int'(idx), e.idx);
                    checkOutput("word_last", int'(last), int'(e.last));
                    checkOutput("word_owner", int'({gnt1, gnt0}), (e.owner == 0) ? 1 : 2);
                end
            end else if (last) begin
                checkOutput("last_without_vld", int'(last), 0);
            end
        end
        prevAddr = addr;
    end

    // Drive one request set while the DUT is idle, check err, queue the
    // expected burst, then check the grant one cycle later.
    task automatic applyStimulus(input bit r0, input int tv0, input bit bv0,
                                 input bit r1, input int tv1, input bit bv1,
                                 output int winner);
        int base;
        req0 = r0;
        t0   = TS_W'(tv0);
        b0   = bv0;
        req1 = r1;
        t1   = TS_W'(tv1);
        b1   = bv1;
        gntCycles = 0;
        #1;
        checkOutput("err0", int'(err0), int'(r0 && (tv0 >= TIMESTEP)));
        checkOutput("err1", int'(err1), int'(r1 && (tv1 >= TIMESTEP)));
        winner = pickWinner(r0, tv0, r1, tv1, modelPrio);
        if (winner >= 0) begin
            if (winner == 0) base = int'(bv0) * NUM * TIMESTEP + tv0 * NUM;
            else             base = int'(bv1) * NUM * TIMESTEP + tv1 * NUM;
            for (int i = 0; i < NUM; i++) begin
                expQ.push_back('{addr: base + i, idx: i, last: (i == NUM - 1), owner: winner});
            end
            modelPrio = 1 - winner;
        end
        @(negedge clk);
        checkOutput("grant", int'({gnt1, gnt0}), (winner == 0) ? 1 : (winner == 1) ? 2 : 0);
    endtask

    // Wait for the burst to end and confirm it was complete.
    task automatic finishBurst();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!gnt0 && !gnt1) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            checkOutput("idle_timeout", int'({gnt1, gnt0}), 0);
        end else begin
            checkOutput("gnt_cycles", gntCycles, NUM + 1);
            checkOutput("queue_drained", expQ.size(), 0);
            checkOutput("idle_vld", int'(vld), 0);
        end
    endtask

    task automatic waitWord(input int n);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (vld && (int'(idx) == n)) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) checkOutput("word_timeout", int'(idx), n);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b0;
        expQ.delete();
        modelPrio = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int w;
        bit r0;
        bit r1;
        total     = 0;
        bad       = 0;
        modelPrio = 0;
        gntCycles = 0;
        prevAddr  = '0;
        rst  = 1'b0;
        req0 = 1'b1;
        t0   = 3'd7;
        b0   = 1'b0;
        req1 = 1'b0;
        t1   = '0;
        b1   = 1'b0;

        // Reset state, with an illegal request held that must not raise err.
        #13;
        checkOutput("rst_addr", int'(addr), 0);
        checkOutput("rst_gnt", int'({gnt1, gnt0}), 0);
        checkOutput("rst_vld_last", int'({vld, last}), 0);
        checkOutput("rst_idx", int'(idx), 0);
        checkOutput("rst_err", int'({err1, err0}), 0);
        req0 = 1'b0;
        t0   = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        $display("[TB] single request, bank 0 timestep 0");
        applyStimulus(1, 0, 0, 0, 0, 0, w);
        req0 = 1'b0;
        finishBurst();

        $display("[TB] top corner, requester 1 bank 1 timestep 6");
        applyStimulus(0, 0, 0, 1, 6, 1, w);
        req1 = 1'b0;
        finishBurst();

        $display("[TB] illegal timestep on requester 0");
        applyStimulus(1, 7, 0, 1, 2, 0, w);
        req0 = 1'b0;
        req1 = 1'b0;
        finishBurst();

        $display("[TB] contention from reset");
        req0 = 1'b1;
        req1 = 1'b1;
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 2, 0, 1, 5, 1, w);
            if (i == 3) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            finishBurst();
        end

        $display("[TB] mid-burst request and timestep changes");
        applyStimulus(1, 3, 0, 0, 0, 0, w);
        waitWord(10);
        req0 = 1'b0;
        t0   = 3'd5;
        b0   = 1'b1;
        finishBurst();

        $display("[TB] reset in the middle of a burst");
        applyStimulus(0, 0, 0, 1, 4, 1, w);
        req1 = 1'b0;
        waitWord(20);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("abort_addr", int'(addr), 0);
        checkOutput("abort_gnt", int'({gnt1, gnt0}), 0);
        checkOutput("abort_vld_last", int'({vld, last}), 0);
        checkOutput("abort_idx", int'(idx), 0);
        expQ.delete();
        modelPrio = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("no_resume", int'({vld, gnt1, gnt0}), 0);
        end

        $display("[TB] randomized requests");
        for (int k = 0; k < 14; k++) begin
            r0 = 1'($urandom_range(0, 1));
            r1 = 1'($urandom_range(0, 1));
            if (!r0 && !r1) r0 = 1'b1;
            applyStimulus(r0, int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                          r1, int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), w);
            if (w < 0) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end else begin
                for (int n = 0; n < 3; n++) begin
                    @(negedge clk);
                    req0 = 1'($urandom_range(0, 1));
                    req1 = 1'($urandom_range(0, 1));
                    t0   = TS_W'($urandom_range(0, 7));
                    t1   = TS_W'($urandom_range(0, 7));
                    b0   = 1'($urandom_range(0, 1));
                    b1   = 1'($urandom_range(0, 1));
                end
                req0 = 1'b0;
                req1 = 1'b0;
                finishBurst();
            end
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/memory_x_sched.md
MEMORY_X_SCHED -- requirements
Module: memory_x_sched

Interface
REQ-001 SHALL have parameter NUM, default 53: words per input vector (one timestep).
REQ-002 SHALL have parameter TIMESTEP, default 7: timesteps per bank.
REQ-003 SHALL have parameter TS_W, default 3: timestep index width.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports req0, req1  input  1 each  burst request from requester 0 (forward pass) and requester 1 (backprop).
REQ-007 SHALL have ports t0, t1  input  TS_W each  requested timestep, sampled with the request.
REQ-008 SHALL have ports b0, b1  input  1 each  requested bank, sampled with the request.
REQ-009 SHALL have port addr  output  12  registered read address to memory_x (1-cycle registered read).
REQ-010 SHALL have ports gnt0, gnt1  output  1 each  registered grant, high for every cycle of the owner's burst (BURST and FLUSH).
REQ-011 SHALL have port vld  output  1  high in the cycle memory_x data for an issued address is valid.
REQ-012 SHALL have port idx  output  6  word index 0..NUM-1 of the data currently qualified by vld.
REQ-013 SHALL have port last  output  1  high with vld on word NUM-1.
REQ-014 SHALL have ports err0, err1  output  1 each  one-cycle pulse on a rejected request.

Function
REQ-015 SHALL implement FSM states IDLE, BURST, FLUSH.
REQ-016 In IDLE, SHALL sample req0/req1 each cycle; a valid request moves to BURST at the next edge, with addr = b*NUM*TIMESTEP + t*NUM and gnt of the winner set.
REQ-017 SHALL arbitrate round-robin: after reset requester 0 has priority; after serving requester n, priority passes to the other requester.
REQ-018 In BURST, SHALL increment addr by 1 per cycle for NUM cycles total (base .. base+NUM-1), then enter FLUSH.
REQ-019 vld SHALL be addr-issue delayed by exactly one cycle; idx SHALL increment with vld, starting at 0.
REQ-020 FLUSH SHALL last one cycle, carrying the final vld/last; it SHALL then return to IDLE with gnt cleared.
REQ-021 Minimum spacing SHALL be one IDLE cycle between consecutive bursts.
REQ-022 A request with t >= TIMESTEP SHALL NOT be granted; it SHALL pulse errN for one cycle in the IDLE cycle it is sampled. The other requester's valid request SHALL be granted in that same cycle.
REQ-023 Requests and t/b changes during BURST/FLUSH SHALL be ignored; the burst SHALL complete using the values latched at grant.
REQ-024 Deasserting the owner's req mid-burst SHALL NOT shorten the burst.
REQ-025 addr SHALL hold its last value when not in BURST; vld, last and gnt SHALL be 0 outside their defined cycles.
REQ-026 Address arithmetic SHALL be 12-bit unsigned; maximum address NUM*TIMESTEP*2-1 (741 at defaults); no wrap SHALL occur for legal t/b.

Reset
REQ-027 On rst low, SHALL asynchronously force state IDLE, addr=0, gnt0=gnt1=0, vld=0, idx=0, last=0, err0=err1=0, and priority to requester 0.
REQ-028 Reset asserted mid-burst SHALL abort the burst immediately; after release, no residual vld and no partial burst SHALL resume.

Verification
REQ-029 Single request: req0, t0=0, b0=0 -> gnt0 for 54 cycles; addr 0..52; vld for 53 cycles lagging addr by 1; last with idx=52.
REQ-030 Top corner: req1, t1=6, b1=1 -> addr 689..741; last at idx=52; gnt1 only.
REQ-031 Contention: req0 and req1 held high from reset -> bursts granted 0,1,0,1, each separated by exactly one IDLE cycle.
REQ-032 Illegal timestep: req0, t0=7 with req1 legal -> err0 pulse, gnt0 stays 0, gnt1 asserted next cycle.
REQ-033 Reset mid-burst: rst low at word 20 of a burst -> all outputs 0 at once; after release, no vld until a new request is granted.
REQ-034 Mid-burst changes: drop req0 and change t0 at word 10 -> burst still issues all 53 sequential addresses from the original base.
